// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes RV32I OP/OP-IMM/LUI/AUIPC into ALU func code + operands.
// Latency 1 cycle; in_ready = !out_valid | out_ready, outputs hold bit-stable while stalled.
// Optional illegal-encoding flag output enabled by defining ILLEGAL_DETECT_EN.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] alu_func,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [4:0]        rd_addr,
`ifdef ILLEGAL_DETECT_EN
    output logic              illegal,
`endif
    output logic              rd_we
);

    localparam logic [FUNC_W-1:0] F_ZERO = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_SLL  = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_XOR  = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_SRL  = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_SRA  = FUNC_W'(9);
    localparam logic [FUNC_W-1:0] F_SLTU = FUNC_W'(10);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_u;
    logic [DATA_W-1:0] shamt;
    logic [FUNC_W-1:0] d_func;
    logic [DATA_W-1:0] d_op1;
    logic [DATA_W-1:0] d_op2;
    logic              d_bad;
    logic              load;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_u  = DATA_W'({instr[31:12], 12'b0});
    assign shamt  = DATA_W'(instr[24:20]);

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // funct3 -> func for the encodings that carry no funct7 alternative
    function automatic logic [FUNC_W-1:0] base_func(input logic [2:0] f3);
        case (f3)
            3'b001:  base_func = F_SLL;
            3'b010:  base_func = F_SLT;
            3'b011:  base_func = F_SLTU;
            3'b100:  base_func = F_XOR;
            3'b110:  base_func = F_OR;
            3'b111:  base_func = F_AND;
            default: base_func = F_ADD;
        endcase
    endfunction

    // Decode the incoming instruction into func/operands; bad encodings collapse to ZERO
    always_comb begin
        d_func = F_ZERO;
        d_op1  = '0;
        d_op2  = '0;
        d_bad  = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_op1 = rs1_data;
                d_op2 = rs2_data;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     d_func = F_ADD;
                        else if (funct7 == F7_ALT) d_func = F_SUB;
                        else                       d_bad  = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     d_func = F_SRL;
                        else if (funct7 == F7_ALT) d_func = F_SRA;
                        else                       d_bad  = 1'b1;
                    end
                    default: begin
                        d_func = base_func(funct3);
                        d_bad  = (funct7 != F7_BASE);
                    end
                endcase
            end
            OPC_IMM: begin
                d_op1 = rs1_data;
                d_op2 = imm_i;
                case (funct3)
                    3'b000: d_func = F_ADD;
                    3'b001: begin
                        d_op2  = shamt;
                        d_func = F_SLL;
                        d_bad  = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        d_op2 = shamt;
                        if (funct7 == F7_BASE)     d_func = F_SRL;
                        else if (funct7 == F7_ALT) d_func = F_SRA;
                        else                       d_bad  = 1'b1;
                    end
                    default: d_func = base_func(funct3);
                endcase
            end
            OPC_LUI: begin
                d_func = F_ADD;
                d_op2  = imm_u;
            end
            OPC_AUIPC: begin
                d_func = F_ADD;
                d_op1  = pc;
                d_op2  = imm_u;
            end
            default: d_bad = 1'b1;
        endcase
        if (d_bad) begin
            d_func = F_ZERO;
            d_op1  = '0;
            d_op2  = '0;
        end
    end

    // Packet valid: flush beats load, load beats consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            out_valid <= 1'b0;
        else if (flush)     out_valid <= 1'b0;
        else if (load)      out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
    end

    // Packet payload: captured only on load, so it stays frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_func <= F_ZERO;
            alu_op1  <= '0;
            alu_op2  <= '0;
            rd_addr  <= 5'd0;
            rd_we    <= 1'b0;
`ifdef ILLEGAL_DETECT_EN
            illegal  <= 1'b0;
`endif
        end else if (load) begin
            alu_func <= d_func;
            alu_op1  <= d_op1;
            alu_op2  <= d_op2;
            rd_addr  <= instr[11:7];
            rd_we    <= !d_bad && (instr[11:7] != 5'd0);
`ifdef ILLEGAL_DETECT_EN
            illegal  <= d_bad;
`endif
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, stall, flush, async reset.
// Inputs driven and outputs sampled 1ns after the rising edge.
// Illegal-flag checks compile in only when ILLEGAL_DETECT_EN is defined.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_func;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [4:0]  rd_addr;
    logic        rd_we;
`ifdef ILLEGAL_DETECT_EN
    logic        illegal;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(32), .FUNC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_func  (alu_func),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .rd_addr   (rd_addr),
`ifdef ILLEGAL_DETECT_EN
        .illegal   (illegal),
`endif
        .rd_we     (rd_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input string tag, input logic v, input logic [3:0] f,
                           input logic [31:0] o1, input logic [31:0] o2,
                           input logic [4:0] rd, input logic we);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".func"},  32'(alu_func),  32'(f));
        chk({tag, ".op1"},   alu_op1,        o1);
        chk({tag, ".op2"},   alu_op2,        o2);
        chk({tag, ".rd"},    32'(rd_addr),   32'(rd));
        chk({tag, ".we"},    32'(rd_we),     32'(we));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = 32'h0; pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk_pkt("reset", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
`ifdef ILLEGAL_DETECT_EN
        chk("reset.illegal", 32'(illegal), 32'h0);
`endif
        rst = 1'b0;
        #1 chk("reset.in_ready", 32'(in_ready), 32'h1);

        // sub a0,a0,a1
        in_valid = 1'b1; instr = 32'h40B50533; rs1_data = 32'd7; rs2_data = 32'd3;
        tick();
        chk_pkt("sub", 1'b1, 4'd2, 32'd7, 32'd3, 5'd10, 1'b1);

        // addi x0,x0,0 back-to-back
        instr = 32'h00000013; rs1_data = 32'd0; rs2_data = 32'd9;
        tick();
        chk_pkt("nop", 1'b1, 4'd1, 32'h0, 32'h0, 5'd0, 1'b0);

        // srai x5,x6,4
        instr = 32'h40435293; rs1_data = 32'h80;
        tick();
        chk_pkt("srai", 1'b1, 4'd9, 32'h80, 32'd4, 5'd5, 1'b1);

        // auipc x1,0x12345 at pc=0x100
        instr = 32'h12345097; pc = 32'h100;
        tick();
        chk_pkt("auipc", 1'b1, 4'd1, 32'h100, 32'h12345000, 5'd1, 1'b1);

        // stall three cycles with add x3,x1,x2 waiting
        out_ready = 1'b0; instr = 32'h002081B3; rs1_data = 32'd1; rs2_data = 32'd2;
        #1 chk("stall.in_ready0", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pkt("stall.hold", 1'b1, 4'd1, 32'h100, 32'h12345000, 5'd1, 1'b1);
            chk("stall.in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1 chk("release.in_ready", 32'(in_ready), 32'h1);
        tick();
        chk_pkt("add", 1'b1, 4'd1, 32'd1, 32'd2, 5'd3, 1'b1);

        // sltiu x4,x2,-1
        instr = 32'hFFF13213; rs1_data = 32'd2;
        tick();
        chk_pkt("sltiu", 1'b1, 4'd10, 32'd2, 32'hFFFFFFFF, 5'd4, 1'b1);

        // and with funct7=0x20 is not a valid encoding
        instr = 32'h4020F1B3; rs1_data = 32'd5; rs2_data = 32'd6;
        tick();
        chk_pkt("bad_and", 1'b1, 4'd0, 32'h0, 32'h0, 5'd3, 1'b0);
`ifdef ILLEGAL_DETECT_EN
        chk("bad_and.illegal", 32'(illegal), 32'h1);
`endif

        // flush while holding with a new instruction offered
        out_ready = 1'b0; instr = 32'h002081B3; rs1_data = 32'd1; rs2_data = 32'd2;
        flush = 1'b1;
        tick();
        chk("flush.valid", 32'(out_valid), 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush.idle", 32'(out_valid), 32'h0);

        // load, hold, then async reset between edges
        in_valid = 1'b1;
        tick();
        chk_pkt("hold.add", 1'b1, 4'd1, 32'd1, 32'd2, 5'd3, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("hold.valid", 32'(out_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_pkt("async_rst", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        chk("async_rst.in_ready", 32'(in_ready), 32'h1);
        tick();
        rst = 1'b0;

        // unrecognised opcode
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0000007F;
        tick();
        chk_pkt("bad_opc", 1'b1, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
`ifdef ILLEGAL_DETECT_EN
        chk("bad_opc.illegal", 32'(illegal), 32'h1);
`endif
        in_valid = 1'b0;
        tick();
        chk("drain.valid", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
